// File: rtl/filter_pkg.sv
// Shared types and arithmetic helpers for the averaging filter family.
package filter_pkg;

    typedef enum logic {
        FILT_MODE_BLOCK   = 1'b0,
        FILT_MODE_SLIDING = 1'b1
    } filt_mode_e;

    // Width of the helper datapath; callers extend their accumulator into it.
    localparam int RS_W = 64;

    function automatic int acc_width(input int io_b, input int max_log2);
        return io_b + max_log2;
    endfunction

    // Divide by 2^l, optionally rounding half up first; arithmetic shift when is_signed.
    function automatic logic [RS_W-1:0] round_shift(
        input logic [RS_W-1:0] val,
        input logic [7:0]      l,
        input logic            is_signed,
        input logic            do_round
    );
        logic [RS_W-1:0] rnd;
        logic [RS_W-1:0] sum;
        rnd = (do_round && (l != 8'd0)) ? (RS_W'(1) << (l - 8'd1)) : '0;
        sum = val + rnd;
        if (is_signed) begin
            return $unsigned($signed(sum) >>> l);
        end
        return sum >> l;
    endfunction

endpackage

// File: rtl/filter_hist_ram.sv
// Sample history for the sliding window: simple dual-port, read-before-write, no reset.
module filter_hist_ram
    import filter_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data
);

    logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/filter_mavg.sv
// Averaging filter: decimating block average or boxcar moving average over 2^L samples,
// fixed two-cycle latency from accepted sample to output strobe.
module filter_mavg
    import filter_pkg::*;
#(
    parameter int IO_B     = 16,
    parameter int MAX_LOG2 = 8,
    parameter int SIGNED   = 0,
    parameter int ROUND    = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cfg_mode,
    input  logic [$clog2(MAX_LOG2+1)-1:0]  cfg_log2_len,
    input  logic                           clear,
    input  logic [IO_B-1:0]                in_data,
    input  logic                           in_valid,
    output logic [IO_B-1:0]                out_data,
    output logic                           out_valid,
    output logic                           out_full
);

    localparam int ACC_B = acc_width(IO_B, MAX_LOG2);
    localparam int LW    = $clog2(MAX_LOG2 + 1);
    localparam logic [LW-1:0] L_MAX = LW'(MAX_LOG2);

    filt_mode_e             mode_q;
    logic [LW-1:0]          log2_q;
    logic [MAX_LOG2-1:0]    wr_ptr;
    logic [MAX_LOG2-1:0]    ptr_mask;
    logic                   fill;
    logic                   accept;
    logic                   win_last;

    logic                   vld_p1;
    logic [IO_B-1:0]        x_p1;
    logic                   last_p1;
    logic                   fill_p1;
    logic [IO_B-1:0]        x_old_p1;

    logic signed [ACC_B-1:0] acc;
    logic signed [ACC_B-1:0] x_ext;
    logic signed [ACC_B-1:0] x_old_ext;
    logic signed [ACC_B-1:0] acc_new;
    logic [IO_B-1:0]         avg_new;
    logic                    vld_p2;
    logic                    full_p2;

    function automatic logic signed [ACC_B-1:0] widen(input logic [IO_B-1:0] x);
        return {{MAX_LOG2{(SIGNED != 0) & x[IO_B-1]}}, x};
    endfunction

    function automatic logic [IO_B-1:0] scale_out(
        input logic signed [ACC_B-1:0] a,
        input logic [LW-1:0]           l
    );
        return IO_B'(round_shift({{(RS_W-ACC_B){(SIGNED != 0) & a[ACC_B-1]}}, a},
                                 8'(l), SIGNED != 0, ROUND != 0));
    endfunction

    assign accept   = in_valid & ~clear;
    assign ptr_mask = ~({MAX_LOG2{1'b1}} << log2_q);
    assign win_last = (wr_ptr == ptr_mask);

    // wr_ptr doubles as the block sample counter: both count 0..N-1 per accepted sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= FILT_MODE_BLOCK;
            log2_q <= L_MAX;
            wr_ptr <= '0;
            fill   <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (clear) begin
            mode_q <= filt_mode_e'(cfg_mode);
            log2_q <= (cfg_log2_len > L_MAX) ? L_MAX : cfg_log2_len;
            wr_ptr <= '0;
            fill   <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                wr_ptr <= (wr_ptr + MAX_LOG2'(1)) & ptr_mask;
                if (win_last) begin
                    fill <= 1'b1;
                end
            end
        end
    end

    // ---- stage 1: capture sample and window position ----
    always_ff @(posedge clk) begin
        if (accept) begin
            x_p1    <= in_data;
            last_p1 <= win_last;
            fill_p1 <= fill;
        end
    end

    filter_hist_ram #(
        .DEPTH_LOG2 (MAX_LOG2),
        .WIDTH      (IO_B)
    ) u_hist (
        .clk     (clk),
        .rd_en   (accept),
        .rd_addr (wr_ptr),
        .rd_data (x_old_p1),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (in_data)
    );

    // Until the window has wrapped once, history entries are stale and count as zero.
    always_comb begin
        x_ext     = widen(x_p1);
        x_old_ext = fill_p1 ? widen(x_old_p1) : '0;
        if (mode_q == FILT_MODE_SLIDING) begin
            acc_new = acc + x_ext - x_old_ext;
        end else begin
            acc_new = acc + x_ext;
        end
        avg_new = scale_out(acc_new, log2_q);
    end

    // ---- stage 2: accumulate and register output ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            out_data <= '0;
            vld_p2   <= 1'b0;
            full_p2  <= 1'b0;
        end else if (clear) begin
            acc     <= '0;
            vld_p2  <= 1'b0;
            full_p2 <= 1'b0;
        end else begin
            vld_p2 <= 1'b0;
            if (vld_p1) begin
                if (mode_q == FILT_MODE_SLIDING) begin
                    acc <= acc_new;
                    if (fill_p1 | last_p1) begin
                        vld_p2   <= 1'b1;
                        full_p2  <= 1'b1;
                        out_data <= avg_new;
                    end
                end else begin
                    acc <= last_p1 ? '0 : acc_new;
                    if (last_p1) begin
                        vld_p2   <= 1'b1;
                        out_data <= avg_new;
                    end
                end
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_full  = full_p2;

endmodule

// File: tb/tb_filter_mavg.sv
// Directed bench for filter_mavg: unsigned and signed instances share stimulus and are
// compared every cycle against a queue-based averaging model.
module tb_filter_mavg;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_mode = 1'b0;
    logic [3:0]  cfg_log2_len = 4'd0;
    logic        clear = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_valid = 1'b0;

    logic [15:0] out_data_u, out_data_s;
    logic        out_valid_u, out_valid_s;
    logic        out_full_u, out_full_s;

    always #5 clk = ~clk;

    filter_mavg #(.IO_B(16), .MAX_LOG2(8), .SIGNED(0), .ROUND(1)) dut_u (
        .clk(clk), .reset_n(reset_n), .cfg_mode(cfg_mode), .cfg_log2_len(cfg_log2_len),
        .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data_u), .out_valid(out_valid_u), .out_full(out_full_u)
    );

    filter_mavg #(.IO_B(16), .MAX_LOG2(8), .SIGNED(1), .ROUND(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .cfg_mode(cfg_mode), .cfg_log2_len(cfg_log2_len),
        .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data_s), .out_valid(out_valid_s), .out_full(out_full_s)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] d_u;
        logic [15:0] d_s;
        bit          full;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] blk_q[$];
    logic [15:0] win_q[$];
    bit          m_mode;
    int          m_l;
    int          cyc = 0;
    bit          exp_v;
    bit          exp_full;
    logic [15:0] exp_du, exp_ds;

    function automatic logic [15:0] mean_of(input logic [15:0] s[$], input int l, input bit sg);
        longint sum;
        sum = 0;
        foreach (s[i]) sum += sg ? longint'($signed(s[i])) : longint'(s[i]);
        if (l > 0) sum += longint'(1) << (l - 1);
        return 16'(sum >>> l);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            blk_q.delete();
            win_q.delete();
            m_mode   = 1'b0;
            m_l      = 8;
            exp_v    = 1'b0;
            exp_full = 1'b0;
        end else begin
            cyc++;
            exp_v = 1'b0;
            if (clear) begin
                m_mode = cfg_mode;
                m_l    = (int'(cfg_log2_len) > 8) ? 8 : int'(cfg_log2_len);
                exp_q.delete();
                blk_q.delete();
                win_q.delete();
                exp_full = 1'b0;
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    exp_v  = 1'b1;
                    exp_du = exp_q[0].d_u;
                    exp_ds = exp_q[0].d_s;
                    if (exp_q[0].full) exp_full = 1'b1;
                    void'(exp_q.pop_front());
                end
                if (in_valid) begin
                    if (!m_mode) begin
                        blk_q.push_back(in_data);
                        if (blk_q.size() == (1 << m_l)) begin
                            exp_q.push_back('{cyc + 1, mean_of(blk_q, m_l, 1'b0),
                                              mean_of(blk_q, m_l, 1'b1), 1'b0});
                            blk_q.delete();
                        end
                    end else begin
                        win_q.push_back(in_data);
                        if (win_q.size() > (1 << m_l)) void'(win_q.pop_front());
                        if (win_q.size() == (1 << m_l))
                            exp_q.push_back('{cyc + 1, mean_of(win_q, m_l, 1'b0),
                                              mean_of(win_q, m_l, 1'b1), 1'b1});
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] got_u[$];
    logic [15:0] got_s[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("out_valid_u", 32'(out_valid_u), 32'(exp_v));
        check("out_valid_s", 32'(out_valid_s), 32'(exp_v));
        check("out_full_u", 32'(out_full_u), 32'(exp_full));
        check("out_full_s", 32'(out_full_s), 32'(exp_full));
        if (exp_v) begin
            check("out_data_u", 32'(out_data_u), 32'(exp_du));
            check("out_data_s", 32'(out_data_s), 32'(exp_ds));
        end
        if (out_valid_u) got_u.push_back(out_data_u);
        if (out_valid_s) got_s.push_back(out_data_s);
    endtask

    task automatic send(input logic [15:0] v);
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_clear(input bit mode, input int l, input bit with_valid);
        clear        = 1'b1;
        cfg_mode     = mode;
        cfg_log2_len = 4'(l);
        in_data      = 16'd200;
        in_valid     = with_valid;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        cfg_mode = ~mode;
        cfg_log2_len = 4'd1;
    endtask

    task automatic lit(input string name, input bit sgn, input int idx, input logic [15:0] req);
        logic [15:0] v;
        if (sgn) v = (idx < got_s.size()) ? got_s[idx] : 16'hDEAD;
        else     v = (idx < got_u.size()) ? got_u[idx] : 16'hDEAD;
        check(name, 32'(v), 32'(req));
    endtask

    initial begin
        int bu, bs;

        idle(2);
        check("reset out_data_u", 32'(out_data_u), 32'h0);
        check("reset out_data_s", 32'(out_data_s), 32'h0);
        reset_n = 1'b1;
        idle(1);

        // BLOCK L=2: 1..8 -> 3, 7
        do_clear(1'b0, 2, 1'b0);
        bu = got_u.size();
        for (int i = 1; i <= 8; i++) send(16'(i));
        idle(3);
        check("blk count", 32'(got_u.size() - bu), 32'd2);
        lit("blk avg0", 1'b0, bu, 16'd3);
        lit("blk avg1", 1'b0, bu + 1, 16'd7);

        // SLIDING L=2: 4,8,12,16,20 -> 10, 14
        do_clear(1'b1, 2, 1'b0);
        bu = got_u.size();
        for (int i = 1; i <= 5; i++) send(16'(4 * i));
        idle(3);
        check("sld count", 32'(got_u.size() - bu), 32'd2);
        lit("sld avg0", 1'b0, bu, 16'd10);
        lit("sld avg1", 1'b0, bu + 1, 16'd14);
        check("sld full", 32'(out_full_u), 32'd1);

        // Signed BLOCK L=1: -3,-4 -> -3; 5,6 -> 6
        do_clear(1'b0, 1, 1'b0);
        bs = got_s.size();
        send(16'hFFFD); send(16'hFFFC); send(16'd5); send(16'd6);
        idle(3);
        lit("sgn avg0", 1'b1, bs, 16'hFFFD);
        lit("sgn avg1", 1'b1, bs + 1, 16'h0006);

        // SLIDING L=3, constant 100 every third cycle
        do_clear(1'b1, 3, 1'b0);
        bu = got_u.size();
        for (int i = 0; i < 12; i++) begin
            send(16'd100);
            idle(2);
        end
        idle(2);
        check("sparse count", 32'(got_u.size() - bu), 32'd5);
        for (int i = 0; i < 5; i++) lit("sparse avg", 1'b0, bu + i, 16'd100);

        // Partial block discarded by clear; sample coincident with clear dropped
        do_clear(1'b0, 3, 1'b0);
        bu = got_u.size();
        for (int i = 0; i < 5; i++) send(16'd50);
        do_clear(1'b0, 3, 1'b1);
        for (int i = 0; i < 8; i++) send(16'd16);
        idle(3);
        check("partial count", 32'(got_u.size() - bu), 32'd1);
        lit("partial avg", 1'b0, bu, 16'd16);

        // L=0 passthrough in both modes
        do_clear(1'b0, 0, 1'b0);
        bu = got_u.size();
        send(16'd7);
        idle(3);
        lit("pass blk", 1'b0, bu, 16'd7);
        do_clear(1'b1, 0, 1'b0);
        bu = got_u.size();
        send(16'd9); send(16'd11);
        idle(3);
        lit("pass sld0", 1'b0, bu, 16'd9);
        lit("pass sld1", 1'b0, bu + 1, 16'd11);

        // Oversized L clamps to MAX_LOG2
        do_clear(1'b1, 15, 1'b0);
        bu = got_u.size();
        for (int i = 0; i < 257; i++) send(16'd1000);
        idle(3);
        check("clamp count", 32'(got_u.size() - bu), 32'd2);
        lit("clamp avg", 1'b0, bu, 16'd1000);

        // Async reset mid-stream
        do_clear(1'b1, 0, 1'b0);
        in_data  = 16'h1234;
        in_valid = 1'b1;
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst out_valid_u", 32'(out_valid_u), 32'd0);
        check("rst out_valid_s", 32'(out_valid_s), 32'd0);
        check("rst out_data_u", 32'(out_data_u), 32'd0);
        check("rst out_full_u", 32'(out_full_u), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        bu = got_u.size();
        bs = got_s.size();
        for (int i = 0; i < 256; i++) send(16'(i));
        idle(3);
        check("post-rst count", 32'(got_u.size() - bu), 32'd1);
        lit("post-rst avg", 1'b0, bu, 16'd128);
        lit("post-rst avg s", 1'b1, bs, 16'd128);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_mavg.md
Name: filter_mavg

Overview:
Parametrised averaging filter for sensor sample streams, with two run-time modes.
- BLOCK mode: decimating average, one output per N input samples.
- SLIDING mode: boxcar moving average, one output per input sample once the window is full.
- Window N = 2^L, where L is run-time selectable up to MAX_LOG2. A history buffer holds the last N samples for sliding mode.
- Sits between the frequency/period measurement front-end and the control/synthesis logic.

Parameters:
IO_B, 16, input and output sample width
MAX_LOG2, 8, maximum window log2; history depth is 2^MAX_LOG2
SIGNED, 0, 1 = two's-complement samples with arithmetic shift; 0 = unsigned
ROUND, 1, 1 = round half up before the shift; 0 = truncate

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_mode  in  1  0 = BLOCK, 1 = SLIDING; latched on clear
cfg_log2_len  in  $clog2(MAX_LOG2+1)  window log2 L; latched on clear; values above MAX_LOG2 clamp to MAX_LOG2
clear  in  1  synchronous flush and config latch
in_data  in  IO_B  input sample
in_valid  in  1  sample strobe; accepted every cycle it is high, back-to-back allowed
out_data  out  IO_B  averaged sample
out_valid  out  1  one-cycle strobe qualifying out_data
out_full  out  1  SLIDING mode: window filled; BLOCK mode: always 0

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values: out_data=0, out_valid=0, out_full=0, accumulator=0, counters and pointers=0, pipeline valids=0, mode=BLOCK, L=MAX_LOG2.
- Clear:
  - clear=1 zeroes the accumulator, sample counter, write pointer, fill flag and pipeline valids.
  - It latches cfg_mode and cfg_log2_len.
  - out_valid is 0 the following cycle.
  - in_valid coincident with clear is dropped.
  - Config inputs are ignored outside clear.
- Accumulator width ACC_B = IO_B+MAX_LOG2; no overflow is possible.
- Latency: fixed 2 cycles in both modes. out_valid asserts exactly 2 cycles after the accepted in_valid that produces it.
  - Stage 1: register the sample and read the history RAM at wr_ptr (read-before-write).
  - Stage 2: update the accumulator and register the output.
  - Stage-2 output: out_data = (acc_new + RND) >> L, where RND = 2^(L-1) if ROUND and L>0, else 0. The shift is arithmetic if SIGNED. The low IO_B bits are kept; the result always fits.
- BLOCK mode:
  - Sample counter counts 0..N-1.
  - On the N-th accepted sample: emit out_data from acc+x, load acc with 0 and wrap the counter to 0.
  - The next sample, even in the immediately following cycle, belongs to the next block; no sample is lost.
- SLIDING mode:
  - acc_new = acc + x - x_old, where x_old is the history entry at wr_ptr, forced to 0 until the fill flag is set.
  - x is written at wr_ptr; wr_ptr = (wr_ptr+1) mod N.
  - The fill flag sets when the N-th sample is accepted; out_full follows with the same 2-cycle latency.
  - out_valid pulses for every accepted sample once full, including the N-th sample.
- L=0: passthrough, out_data = in_data with 2-cycle latency, in either mode.
- Idle cycles (in_valid=0) never assert out_valid and do not change acc.
- Reset mid-stream: all state and pipeline contents are discarded immediately. After release, the first output requires N fresh samples.

Decomposition:
- Package filter_pkg:
  - typedef enum {FILT_MODE_BLOCK, FILT_MODE_SLIDING}
  - localparam function for ACC_B
  - shared rounding/shift helper function, parametrised on SIGNED
- One sub-module, filter_hist_ram:
  - simple dual-port, depth 2^MAX_LOG2, width IO_B
  - synchronous read-before-write, 1-cycle read latency
  - no reset on contents; the fill flag masks stale data

Test Plan:
- BLOCK, L=2, unsigned: in 1..8 back-to-back -> out_valid 2 cycles after the 4th and 8th sample with out_data 3 then 7; no other strobes.
- SLIDING, L=2: in 4,8,12,16,20 -> no output for the first 3; then 10 and 14; out_full rises with the output of the 4th sample.
- SIGNED=1, BLOCK, L=1: in -3,-4 -> out -3 (0xFFFD); then in 5,6 -> out 6.
- SLIDING, L=3, constant 100 with in_valid every 3rd cycle -> first output 100 after the 8th sample, then 100 per sample; out_valid never asserts on idle cycles.
- BLOCK, L=3: 5 samples of 50, then clear, then 8 samples of 16 -> exactly one output, 16; nothing from the partial block. Also L=0: in 7 -> out 7 after 2 cycles.
- Async reset asserted mid-stream with in_valid high -> out_valid/out_data go 0 without a clock; after release, mode=BLOCK and L=MAX_LOG2, and the first output needs 2^MAX_LOG2 samples.
